// File: rtl/m_cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the z24 vectoring CORDIC.
// Phase format: 24-bit two's complement full circle, 2^23 = pi.
package m_cordic_pkg;

  localparam int ZWIDTH     = 24;
  localparam int MAX_STAGES = 20;
  localparam int GAIN_COMP  = 19898;  // round(2^15 / 1.64676)

  localparam logic [ZWIDTH-1:0] PHASE_PI = 24'h80_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_GAIN,
    ST_DONE
  } state_t;

  // atan(2^-i) in phase units; indices past the table return 0.
  function automatic logic [ZWIDTH-1:0] atan_c(input logic [4:0] i);
    case (i)
      5'd0:    atan_c = 24'd2097152;
      5'd1:    atan_c = 24'd1238021;
      5'd2:    atan_c = 24'd654136;
      5'd3:    atan_c = 24'd332050;
      5'd4:    atan_c = 24'd166669;
      5'd5:    atan_c = 24'd83416;
      5'd6:    atan_c = 24'd41718;
      5'd7:    atan_c = 24'd20860;
      5'd8:    atan_c = 24'd10430;
      5'd9:    atan_c = 24'd5215;
      5'd10:   atan_c = 24'd2608;
      5'd11:   atan_c = 24'd1304;
      5'd12:   atan_c = 24'd652;
      5'd13:   atan_c = 24'd326;
      5'd14:   atan_c = 24'd163;
      5'd15:   atan_c = 24'd81;
      5'd16:   atan_c = 24'd41;
      5'd17:   atan_c = 24'd20;
      5'd18:   atan_c = 24'd10;
      5'd19:   atan_c = 24'd5;
      default: atan_c = '0;
    endcase
  endfunction

endpackage

// File: rtl/m_cordic_vec_step.sv
// One vectoring micro-rotation: drives y towards zero and accumulates the angle in z.
// Purely combinational; the top reuses a single instance for every iteration.
module m_cordic_vec_step
  import m_cordic_pkg::*;
#(
  parameter int W = 18
) (
  input  logic signed [W-1:0]      x,
  input  logic signed [W-1:0]      y,
  input  logic        [ZWIDTH-1:0] z,
  input  logic        [4:0]        i,
  input  logic        [ZWIDTH-1:0] c,
  output logic signed [W-1:0]      x_n,
  output logic signed [W-1:0]      y_n,
  output logic        [ZWIDTH-1:0] z_n
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  assign x_sh = x >>> i;
  assign y_sh = y >>> i;

  always_comb begin
    if (y[W-1]) begin
      x_n = x - y_sh;
      y_n = y + x_sh;
      z_n = z - c;
    end else begin
      x_n = x + y_sh;
      y_n = y - x_sh;
      z_n = z + c;
    end
  end

endmodule

// File: rtl/m_cordic_vec_z24.sv
// Iterative vectoring CORDIC: (xi, yi) -> magnitude and atan2 phase, one micro-rotation per clock.
// Define CORDIC_VEC_GAINCOMP_EN to add a GAIN state that removes the CORDIC gain from mag.
module m_cordic_vec_z24
  import m_cordic_pkg::*;
#(
  parameter int bitwidth = 16,
  parameter int stages   = 20
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic signed [bitwidth-1:0] xi,
  input  logic signed [bitwidth-1:0] yi,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic        [bitwidth-1:0] mag,
  output logic        [ZWIDTH-1:0]   zo,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int XW = bitwidth + 2;
  // The counter runs one past the last step; that extra cycle registers the result.
  localparam logic [4:0] LAST = 5'(stages);

  state_t state;
  state_t state_nx;

  logic signed [XW-1:0]     x_q, y_q, x_nx, y_nx;
  logic signed [XW-1:0]     xi_ext, yi_ext;
  logic        [ZWIDTH-1:0] z_q, z_nx, c_i;
  logic        [4:0]        iter_q;
  logic                     live_q;
  logic                     take;
  logic                     last_iter;

  assign xi_ext    = {{2{xi[bitwidth-1]}}, xi};
  assign yi_ext    = {{2{yi[bitwidth-1]}}, yi};
  assign take      = enable & in_valid & in_ready;
  assign last_iter = (iter_q == LAST);
  assign c_i       = atan_c(iter_q);

  m_cordic_vec_step #(.W(XW)) u_step (
    .x  (x_q),
    .y  (y_q),
    .z  (z_q),
    .i  (iter_q),
    .c  (c_i),
    .x_n(x_nx),
    .y_n(y_nx),
    .z_n(z_nx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    state <= ST_IDLE;
    else if (enable) state <= state_nx;
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid && live_q) state_nx = ST_ITER;
`ifdef CORDIC_VEC_GAINCOMP_EN
      ST_ITER: if (last_iter) state_nx = ST_GAIN;
`else
      ST_ITER: if (last_iter) state_nx = ST_DONE;
`endif
      ST_GAIN: state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && live_q;
    out_valid = (state == ST_DONE);
  end

`ifdef CORDIC_VEC_GAINCOMP_EN
  localparam int PW = XW + 17;
  localparam logic signed [PW-1:0] GAIN_K = PW'(GAIN_COMP);

  logic signed [PW-1:0]       prod;
  logic signed [PW-1:0]       prod_sh;
  logic        [bitwidth-1:0] gain_mag;

  assign prod    = PW'(x_q) * GAIN_K;
  assign prod_sh = prod >>> 15;

  always_comb begin
    gain_mag = prod_sh[bitwidth-1:0];
    if (prod_sh[PW-1])                    gain_mag = '0;
    else if (|prod_sh[PW-2:bitwidth])     gain_mag = '1;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      iter_q <= '0;
      mag    <= '0;
      zo     <= '0;
      live_q <= 1'b0;
    end else if (enable) begin
      live_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (take) begin
            iter_q <= '0;
            // Fold the left half-plane onto the right so the iteration only covers +-pi/2.
            if (xi[bitwidth-1]) begin
              x_q <= -xi_ext;
              y_q <= -yi_ext;
              z_q <= PHASE_PI;
            end else begin
              x_q <= xi_ext;
              y_q <= yi_ext;
              z_q <= '0;
            end
          end
        end
        ST_ITER: begin
          if (!last_iter) begin
            x_q    <= x_nx;
            y_q    <= y_nx;
            z_q    <= z_nx;
            iter_q <= iter_q + 5'd1;
          end else begin
`ifndef CORDIC_VEC_GAINCOMP_EN
            mag <= x_q[bitwidth:1];
            zo  <= z_q;
`endif
          end
        end
`ifdef CORDIC_VEC_GAINCOMP_EN
        ST_GAIN: begin
          mag <= gain_mag;
          zo  <= z_q;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_cordic_vec_z24.sv
// Scoreboard bench for m_cordic_vec_z24: a real-valued atan2/hypot model predicts each result.
// Honours CORDIC_VEC_GAINCOMP_EN for the expected magnitude scale and latency.
module tb_m_cordic_vec_z24;

  localparam int BW = 16;
  localparam int ST = 20;
`ifdef CORDIC_VEC_GAINCOMP_EN
  localparam int  LAT       = ST + 2;
  localparam real MAG_SCALE = 1.0;
`else
  localparam int  LAT       = ST + 1;
  localparam real MAG_SCALE = 1.6467602581 / 2.0;
`endif
  localparam real PI   = 3.14159265358979;
  localparam real TURN = 16777216.0;

  logic                 clock;
  logic                 reset_n;
  logic                 enable;
  logic signed [BW-1:0] xi;
  logic signed [BW-1:0] yi;
  logic                 in_valid;
  logic                 in_ready;
  logic        [BW-1:0] mag;
  logic        [23:0]   zo;
  logic                 out_valid;
  logic                 out_ready;

  m_cordic_vec_z24 #(.bitwidth(BW), .stages(ST)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .xi       (xi),
    .yi       (yi),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mag      (mag),
    .zo       (zo),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string  tag;
    longint mag;
    longint zo;
    longint zo_tol;
    bit     chk_zo;
    int     acc;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   checks   = 0;
  int   errors   = 0;
  int   en_cyc   = 0;
  bit   seen     = 1'b0;
  bit   hold_chk = 1'b0;
  logic [BW-1:0] held_mag;
  logic [23:0]   held_zo;

  always @(posedge clock) if (enable) en_cyc++;

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol, input bit wrap);
    longint d;
    checks++;
    d = got - exp;
    if (wrap) begin
      d = d & 64'hFF_FFFF;
      if (d >= 8388608) d = d - 16777216;
    end
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic exp_t model(input string tag, input int x, input int y, input int acc);
    exp_t e;
    real  r;
    real  a;
    r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    a = $atan2(real'(y), real'(x));
    e.tag    = tag;
    e.mag    = longint'(r * MAG_SCALE);
    e.zo     = longint'(a / (2.0 * PI) * TURN);
    e.chk_zo = (r >= 4096.0);
    // Truncating shifts leave the final vector a few LSBs off axis; one LSB of x is this much phase.
    e.zo_tol = 4 + longint'(6.0 * TURN / (2.0 * PI) / (r * 1.6467602581 + 1.0));
    e.acc    = acc;
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen     = 1'b1;
        held_mag = mag;
        held_zo  = zo;
        if (sb.size() == 0) check("spurious_out_valid", out_valid, 0, 0, 0);
        else                check({sb[0].tag, "_latency"}, en_cyc - sb[0].acc, LAT, 0, 0);
      end else if (hold_chk) begin
        check("hold_mag", mag, held_mag, 0, 0);
        check("hold_zo", zo, held_zo, 0, 0);
        check("hold_in_ready", in_ready, 0, 0, 0);
      end
      if (out_ready && enable) begin
        seen = 1'b0;
        if (sb.size() > 0) begin
          got_e = sb.pop_front();
          check({got_e.tag, "_mag"}, mag, got_e.mag, 8, 0);
          if (got_e.chk_zo) check({got_e.tag, "_zo"}, zo, got_e.zo, got_e.zo_tol, 1);
        end
      end
    end
  end

  task automatic send(input int x, input int y, input string tag);
    @(posedge clock); #1;
    xi       = BW'(x);
    yi       = BW'(y);
    in_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (in_ready && enable && reset_n) begin
        sb.push_back(model(tag, x, y, en_cyc + 1));
        @(posedge clock); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check({tag, "_accept"}, in_ready, 1, 0, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      if (sb.size() == 0 && !out_valid) return;
    end
    check("drain", sb.size(), 0, 0, 0);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (out_valid) return;
    end
    check("wait_valid", out_valid, 1, 0, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    xi        = '0;
    yi        = '0;
    out_ready = 1'b1;

    #2;
    check("rst_in_ready", in_ready, 0, 0, 0);
    check("rst_out_valid", out_valid, 0, 0, 0);
    check("rst_mag", mag, 0, 0, 0);
    check("rst_zo", zo, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    check("in_ready_after_rst", in_ready, 1, 0, 0);

    // Axis, half-plane fold, most-negative corner and the degenerate origin.
    send(16384, 0, "pos_x");
    send(0, 16384, "pos_y");
    send(-16384, 0, "neg_x");
    send(-32768, -32768, "corner");
    send(0, 0, "origin");
    send(-20000, 12345, "q2");
    drain();

    // Enable low mid-iteration stretches latency by exactly the stalled cycles.
    fork
      send(12000, -9000, "stall");
    join_none
    repeat (8) @(posedge clock);
    #1 enable = 1'b0;
    repeat (5) @(posedge clock);
    #1 enable = 1'b1;
    drain();

    // Output backpressure with a new sample waiting at the input.
    out_ready = 1'b0;
    send(16384, 0, "bp_a");
    wait_valid();
    #1 hold_chk = 1'b1;
    fork
      send(0, -16384, "bp_b");
    join_none
    repeat (10) @(negedge clock);
    #1;
    check("bp_b_not_taken", sb.size(), 1, 0, 0);
    hold_chk = 1'b0;
    @(posedge clock); #1 out_ready = 1'b1;
    drain();

    // Reset mid-flight discards the sample.
    send(16384, 0, "aborted");
    repeat (8) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_mag", mag, 0, 0, 0);
    check("midrst_zo", zo, 0, 0, 0);
    check("midrst_out_valid", out_valid, 0, 0, 0);
    check("midrst_in_ready", in_ready, 0, 0, 0);
    sb.delete();
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check("no_valid_after_rst", out_valid, 0, 0, 0);
    send(16384, 16384, "post_rst");
    drain();

    for (int k = 0; k < 6; k++) begin
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, "rand");
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
